// File: rtl/ftdi_stream_tester_if.sv
// Send/receive stream bundle between the stream tester and the FTDI FIFO bridge.
interface ftdi_stream_tester_if #(
  parameter int unsigned DSIZE = 2
);
  localparam int unsigned W = 8 * DSIZE;

  logic         itvalid;
  logic         itready;
  logic [W-1:0] itdata;
  logic         otvalid;
  logic         otready;
  logic [W-1:0] otdata;

  // Tester side: sources the send stream, sinks the receive stream.
  modport master (
    output itvalid, itdata, otready,
    input  itready, otvalid, otdata
  );

  // Bridge side.
  modport slave (
    input  itvalid, itdata, otready,
    output itready, otvalid, otdata
  );
endinterface

// File: rtl/ftdi_stream_tester.sv
// Traffic generator and pattern checker for FTDI 245-FIFO link testing.
module ftdi_stream_tester #(
  parameter int unsigned DSIZE = 2,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [LEN_W-1:0]   burst_len,
  input  logic [LEN_W-1:0]   gap_len,
  input  logic               clr,
  ftdi_stream_tester_if.master st,
  output logic [CNT_W-1:0]   tx_cnt,
  output logic [CNT_W-1:0]   rx_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               locked
);

  localparam int unsigned W = 8 * DSIZE;

  // Fibonacci LFSR tap masks (bit tap-1 set for each tap) per supported width.
  localparam logic [63:0] TAPS64 =
    (DSIZE == 1) ? 64'h0000_0000_0000_00B8 :
    (DSIZE == 2) ? 64'h0000_0000_0000_D008 :
    (DSIZE == 4) ? 64'h0000_0000_8020_0003 :
                   64'hD800_0000_0000_0000;
  localparam logic [W-1:0] TAP_MASK = W'(TAPS64);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Pattern successor; mode 3 falls through to INC.
  function automatic logic [W-1:0] next_word(input logic [W-1:0] x, input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd1:    r = {x[W-2:0], ^(x & TAP_MASK)};
      2'd2:    r = ~x;
      default: r = x + W'(1);
    endcase
    return r;
  endfunction

  // Start-of-sequence word for each pattern.
  function automatic logic [W-1:0] seed_word(input logic [1:0] m);
    logic [W-1:0] r;
    case (m)
      2'd1:    r = W'(1);
      2'd2:    r = {DSIZE{8'h55}};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Saturating counter step.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic               itvalid_q, itvalid_d;
  logic [W-1:0]       itdata_q, itdata_d;
  logic               cfg_load, mode_load;
  logic [1:0]         mode_q;
  logic [LEN_W-1:0]   burst_len_q, gap_len_q;
  logic [LEN_W-1:0]   beat_q, gap_q;
  logic               tx_hs, burst_end, gap_end;

  logic               otready_q;
  logic               rx_hs;
  logic [W-1:0]       ref_q;
  logic [1:0]         mode_prev_q;
  logic               mode_chg;

  assign st.itvalid = itvalid_q;
  assign st.itdata  = itdata_q;
  assign st.otready = otready_q;

  assign tx_hs     = itvalid_q & st.itready;
  assign burst_end = (burst_len_q != '0) && (beat_q == burst_len_q - LEN_W'(1));
  assign gap_end   = (gap_q == gap_len_q - LEN_W'(1));
  assign rx_hs     = st.otvalid & otready_q;
  assign mode_chg  = (mode != mode_prev_q);

  // Generator state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Generator next state; a pending word must be accepted before going idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en) state_d = S_BURST;
      S_BURST: begin
        if (tx_hs) begin
          if (!en)                                  state_d = S_IDLE;
          else if (burst_end && gap_len_q != '0)    state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (!en)          state_d = S_IDLE;
        else if (gap_end) state_d = S_BURST;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Generator outputs and config-latch strobes for the coming cycle.
  always_comb begin
    itvalid_d = (state_d == S_BURST);
    itdata_d  = itdata_q;
    cfg_load  = 1'b0;
    mode_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        itdata_d  = seed_word(mode);
        cfg_load  = en;
        mode_load = en;
      end
      S_BURST: if (tx_hs) itdata_d = next_word(itdata_q, mode_q);
      S_GAP:   cfg_load = (state_d == S_BURST);
      default: ;
    endcase
  end

  // Registered send-stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itvalid_q <= 1'b0;
      itdata_q  <= '0;
    end else begin
      itvalid_q <= itvalid_d;
      itdata_q  <= itdata_d;
    end
  end

  // Burst configuration latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 2'd0;
      burst_len_q <= '0;
      gap_len_q   <= '0;
    end else begin
      if (mode_load) mode_q <= mode;
      if (cfg_load) begin
        burst_len_q <= burst_len;
        gap_len_q   <= gap_len;
      end
    end
  end

  // Beat counter within a burst and idle-cycle counter within a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      gap_q  <= '0;
    end else begin
      if (state_q != S_BURST) beat_q <= '0;
      else if (tx_hs)         beat_q <= burst_end ? '0 : beat_q + LEN_W'(1);
      if (state_q != S_GAP)   gap_q  <= '0;
      else                    gap_q  <= gap_q + LEN_W'(1);
    end
  end

  // Receive side is always ready once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) otready_q <= 1'b0;
    else        otready_q <= 1'b1;
  end

  // Checker lock, reference word and mode-change tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked      <= 1'b0;
      ref_q       <= '0;
      mode_prev_q <= 2'd0;
    end else begin
      mode_prev_q <= mode;
      if (clr || mode_chg) locked <= 1'b0;
      else if (rx_hs)      locked <= 1'b1;
      if (rx_hs && !clr)   ref_q  <= st.otdata;
    end
  end

  // Statistics counters; clear wins over a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      tx_cnt  <= '0;
      rx_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (tx_hs) tx_cnt <= sat_inc(tx_cnt);
      if (rx_hs) rx_cnt <= sat_inc(rx_cnt);
      if (rx_hs && locked && !mode_chg && st.otdata != next_word(ref_q, mode))
        err_cnt <= sat_inc(err_cnt);
    end
  end

endmodule
